// File: rtl/dds_reg_writer.sv
// Purpose : serial writer for the DDS control port: one command of an address byte plus 1..MAX_BYTES data bytes, sent MSB-first on CS/SCLK/SDIO, optionally followed by an IO_UPDATE pulse.
// Latency : done asserts SCLK_DIV*(1+2*bits)+1 cycles after start is sampled (update_en=0), or one cycle after start for an illegal byte count.
// Backpr. : a single command is in flight at a time; start is ignored while busy=1 and is never queued.
//
// Ports:
//   clk, rst (async, active low)      - clock and reset
//   start/addr/din/nbytes/update_en   - command inputs, latched on start while idle
//   SYNC_CLK                          - DDS sync clock, asynchronous to clk
//   busy/done/err                     - status; done and err are one-cycle pulses
//   SCLK/CS/SDIO/SYNCIO/IO_UPDATE     - DDS pins, all driven from registers
module dds_reg_writer #(
    parameter int MAX_BYTES = 8,
    parameter int SCLK_DIV  = 2,
    parameter int UPD_CYC   = 4,
    parameter int SYNC_TO   = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             addr,
    input  logic [8*MAX_BYTES-1:0] din,
    input  logic [3:0]             nbytes,
    input  logic                   update_en,
    input  logic                   SYNC_CLK,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   SCLK,
    output logic                   CS,
    output logic                   SDIO,
    output logic                   SYNCIO,
    output logic                   IO_UPDATE
);

    localparam int FW   = 8 * (MAX_BYTES + 1);
    localparam int BW   = $clog2(FW + 1);
    localparam int CMAX = (SCLK_DIV > UPD_CYC) ?
                          ((SCLK_DIV > SYNC_TO) ? SCLK_DIV : SYNC_TO) :
                          ((UPD_CYC > SYNC_TO) ? UPD_CYC : SYNC_TO);
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] C_DIV = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0] C_UPD = CW'(UPD_CYC - 1);
    localparam logic [CW-1:0] C_TO  = CW'(SYNC_TO - 1);

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_SETUP, S_HI, S_LO, S_WAIT, S_UPD, S_FIN, S_DONE
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [BW-1:0]   r_bits, w_bits_nxt;
    logic [FW-1:0]   r_shift, w_shift_nxt;
    logic            r_upd, w_upd_nxt;
    logic            r_err_pend, w_err_pend_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_done, w_done_nxt;
    logic            r_err, w_err_nxt;
    logic            r_sclk, w_sclk_nxt;
    logic            r_cs, w_cs_nxt;
    logic            r_sdio, w_sdio_nxt;
    logic            r_syncio, w_syncio_nxt;
    logic            r_ioupd, w_ioupd_nxt;
    logic            r_sync1, r_sync2, r_sync3;

    logic                   w_bad;
    logic                   w_rise;
    logic [3:0]             w_pad;
    logic [8*MAX_BYTES-1:0] w_din_al;
    logic [BW-1:0]          w_nbits;

    // Command decode. Data is left-aligned so the frame always leaves
    // from the top bit of the shift register whatever nbytes is.
    assign w_bad    = (nbytes == 4'd0) || (int'(nbytes) > MAX_BYTES);
    assign w_pad    = 4'(MAX_BYTES) - nbytes;
    assign w_din_al = din << {w_pad, 3'b000};
    // 8*(nbytes+1)-1: remaining bits after the one presented in SETUP
    assign w_nbits  = BW'({nbytes, 3'b111});

    // SYNC_CLK: two flops for metastability, third flop for edge detect.
    // The rise pulse is only consulted in S_WAIT, so edges seen during
    // the shift are ignored.
    assign w_rise = r_sync2 & ~r_sync3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= SYNC_CLK;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_INIT;
            r_cnt      <= C_DIV;
            r_bits     <= '0;
            r_shift    <= '0;
            r_upd      <= 1'b0;
            r_err_pend <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_sclk     <= 1'b0;
            r_cs       <= 1'b1;
            r_sdio     <= 1'b0;
            r_syncio   <= 1'b1;
            r_ioupd    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bits     <= w_bits_nxt;
            r_shift    <= w_shift_nxt;
            r_upd      <= w_upd_nxt;
            r_err_pend <= w_err_pend_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_sclk     <= w_sclk_nxt;
            r_cs       <= w_cs_nxt;
            r_sdio     <= w_sdio_nxt;
            r_syncio   <= w_syncio_nxt;
            r_ioupd    <= w_ioupd_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_bits_nxt     = r_bits;
        w_shift_nxt    = r_shift;
        w_upd_nxt      = r_upd;
        w_err_pend_nxt = r_err_pend;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_sclk_nxt     = r_sclk;
        w_cs_nxt       = r_cs;
        w_sdio_nxt     = r_sdio;
        w_syncio_nxt   = r_syncio;
        w_ioupd_nxt    = r_ioupd;

        case (r_state)
            S_INIT: begin
                if (r_cnt == '0) begin
                    w_syncio_nxt = 1'b0;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_IDLE: begin
                if (start) begin
                    w_busy_nxt = 1'b1;
                    w_upd_nxt  = update_en;
                    if (w_bad) begin
                        // No pin activity; report from S_FIN next cycle
                        w_err_pend_nxt = 1'b1;
                        w_state_nxt    = S_FIN;
                    end else begin
                        w_err_pend_nxt = 1'b0;
                        w_cs_nxt       = 1'b0;
                        w_sclk_nxt     = 1'b0;
                        w_shift_nxt    = {addr, w_din_al};
                        w_sdio_nxt     = addr[7];
                        w_bits_nxt     = w_nbits;
                        w_cnt_nxt      = C_DIV;
                        w_state_nxt    = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (r_cnt == '0) begin
                    w_sclk_nxt  = 1'b1;
                    w_cnt_nxt   = C_DIV;
                    w_state_nxt = S_HI;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_HI: begin
                if (r_cnt == '0) begin
                    w_sclk_nxt  = 1'b0;
                    w_cnt_nxt   = C_DIV;
                    w_state_nxt = S_LO;
                    // Data moves only on the falling SCLK edge
                    if (r_bits != '0) begin
                        w_shift_nxt = r_shift << 1;
                        w_sdio_nxt  = r_shift[FW-2];
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_LO: begin
                if (r_cnt == '0) begin
                    if (r_bits == '0) begin
                        w_cs_nxt    = 1'b1;
                        w_sdio_nxt  = 1'b0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = r_upd ? S_WAIT : S_FIN;
                    end else begin
                        w_sclk_nxt  = 1'b1;
                        w_bits_nxt  = r_bits - BW'(1);
                        w_cnt_nxt   = C_DIV;
                        w_state_nxt = S_HI;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_WAIT: begin
                if (w_rise) begin
                    w_ioupd_nxt = 1'b1;
                    w_cnt_nxt   = C_UPD;
                    w_state_nxt = S_UPD;
                end else if (r_cnt == C_TO) begin
                    // No sync edge in time: pulse anyway and flag it
                    w_ioupd_nxt    = 1'b1;
                    w_err_pend_nxt = 1'b1;
                    w_cnt_nxt      = C_UPD;
                    w_state_nxt    = S_UPD;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_UPD: begin
                if (r_cnt == '0) begin
                    w_ioupd_nxt = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = r_err_pend;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_FIN: begin
                w_done_nxt  = 1'b1;
                w_err_nxt   = r_err_pend;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                // busy stays up through the done cycle, drops after it
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign SCLK      = r_sclk;
    assign CS        = r_cs;
    assign SDIO      = r_sdio;
    assign SYNCIO    = r_syncio;
    assign IO_UPDATE = r_ioupd;

endmodule
